// File: rtl/reg_file_pkg.sv
// Shared constants and types for the integer register file.
package reg_file_pkg;

    localparam int unsigned WIDTH_ADDR_DEF = 5;
    localparam int unsigned WIDTH_DATA_DEF = 32;

    typedef logic [WIDTH_ADDR_DEF-1:0] reg_addr_t;
    typedef logic [WIDTH_DATA_DEF-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy vector: flush over reserve over writeback-release.
module reg_scoreboard #(
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [$clog2(DEPTH)-1:0] set_addr,
    input  logic                     clr_en,
    input  logic [$clog2(DEPTH)-1:0] clr_addr,
    input  logic                     flush,
    output logic [DEPTH-1:0]         busy,
    output logic                     busy_any
);

    logic [DEPTH-1:0] busy_nxt;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (clr_en) busy_nxt[clr_addr] = 1'b0;
            if (set_en) busy_nxt[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    assign busy_any = |busy;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with combinational bypassed reads and a RAW scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR = WIDTH_ADDR_DEF,
    parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
    parameter int unsigned NUM_RD     = 2,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*WIDTH_ADDR-1:0] rd_addr,
    output logic [NUM_RD*WIDTH_DATA-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wr_en,
    input  logic [WIDTH_ADDR-1:0]        wr_addr,
    input  logic [WIDTH_DATA-1:0]        wr_data,
    input  logic                         resv_en,
    input  logic [WIDTH_ADDR-1:0]        resv_addr,
    input  logic                         flush,
    output logic                         busy_any
);

    localparam int unsigned DEPTH = 2**WIDTH_ADDR;
    localparam logic [WIDTH_ADDR-1:0] ZERO_ADDR = WIDTH_ADDR'(REG_ZERO);

    logic [WIDTH_DATA-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wr_ok;
    logic                  resv_ok;

    assign wr_ok   = wr_en   && !(ZERO_REG && (wr_addr   == ZERO_ADDR));
    assign resv_ok = resv_en && !(ZERO_REG && (resv_addr == ZERO_ADDR));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    reg_scoreboard #(
        .DEPTH(DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (resv_ok),
        .set_addr (resv_addr),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_any (busy_any)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [WIDTH_ADDR-1:0] addr;
        logic                  hit;
        logic                  zero;

        assign addr = rd_addr[i*WIDTH_ADDR +: WIDTH_ADDR];
        assign zero = ZERO_REG && (addr == ZERO_ADDR);
        assign hit  = wr_en && (wr_addr == addr);

        assign rd_data[i*WIDTH_DATA +: WIDTH_DATA] = zero ? '0 :
                                                     hit  ? wr_data :
                                                            regs[addr];
        assign rd_busy[i] = busy[addr] && !hit && !zero;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  import reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        resv_en;
  logic [4:0]  resv_addr;
  logic        flush;
  logic        busy_any;

  typedef enum int {K_DATA, K_BUSY, K_ANY} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    int          port;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  reg_file_sb #(
    .WIDTH_ADDR(5),
    .WIDTH_DATA(32),
    .NUM_RD(2),
    .ZERO_REG(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .flush     (flush),
    .busy_any  (busy_any)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; resv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic exp_data(input string n, input int p, input logic [31:0] v);
    exp_q.push_back('{name: n, kind: K_DATA, port: p, value: v});
  endtask

  task automatic exp_busy(input string n, input int p, input logic v);
    exp_q.push_back('{name: n, kind: K_BUSY, port: p, value: {31'd0, v}});
  endtask

  task automatic exp_any(input string n, input logic v);
    exp_q.push_back('{name: n, kind: K_ANY, port: 0, value: {31'd0, v}});
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        K_DATA:  act = rd_data[e.port*32 +: 32];
        K_BUSY:  act = {31'd0, rd_busy[e.port]};
        default: act = {31'd0, busy_any};
      endcase
      total++;
      if (act !== e.value) begin
        bad++;
        $display("FAIL %s port%0d: got 0x%08h want 0x%08h", e.name, e.port, act, e.value);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_addr = '0; wr_addr = '0; wr_data = '0; resv_addr = '0;
    idle();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFFFF_FFFF;
    resv_en = 1'b1; resv_addr = 5'd2;
    step();
    step();
    idle();

    for (int a = 0; a < 32; a++) begin
      step();
      set_rd(5'(a), 5'(31 - a));
      exp_data("rst_data", 0, 32'h0);
      exp_data("rst_data", 1, 32'h0);
      exp_busy("rst_busy", 0, 1'b0);
      exp_busy("rst_busy", 1, 1'b0);
      exp_any("rst_any", 1'b0);
    end

    step();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    set_rd(5'd5, 5'd6);
    exp_data("bypass_r5", 0, 32'hDEAD_BEEF);
    exp_data("bypass_other", 1, 32'h0);
    step();
    idle();
    set_rd(5'd6, 5'd5);
    exp_data("stored_r5", 1, 32'hDEAD_BEEF);
    exp_data("r6_untouched", 0, 32'h0);

    step();
    wr_en = 1'b1; wr_addr = REG_ZERO; wr_data = 32'h1234_5678;
    set_rd(5'd0, 5'd0);
    exp_data("r0_no_bypass", 0, 32'h0);
    step();
    idle();
    exp_data("r0_no_store", 1, 32'h0);
    resv_en = 1'b1; resv_addr = 5'd0;
    step();
    idle();
    exp_busy("r0_resv_busy", 0, 1'b0);
    exp_any("r0_resv_any", 1'b0);

    step();
    resv_en = 1'b1; resv_addr = 5'd7;
    set_rd(5'd7, 5'd5);
    exp_busy("r7_c0_busy", 0, 1'b0);
    exp_any("r7_c0_any", 1'b0);
    step();
    idle();
    exp_busy("r7_c1_busy", 0, 1'b1);
    exp_busy("r5_not_busy", 1, 1'b0);
    exp_any("r7_c1_any", 1'b1);
    step();
    exp_busy("r7_c2_busy", 0, 1'b1);
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    exp_busy("r7_c3_release", 0, 1'b0);
    exp_data("r7_c3_data", 0, 32'h55);
    exp_any("r7_c3_any", 1'b1);
    step();
    idle();
    exp_busy("r7_c4_busy", 0, 1'b0);
    exp_data("r7_c4_data", 0, 32'h55);
    exp_any("r7_c4_any", 1'b0);

    step();
    resv_en = 1'b1; resv_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
    set_rd(5'd9, 5'd9);
    exp_data("r9_bypass", 1, 32'hAA);
    step();
    idle();
    exp_busy("r9_still_busy", 0, 1'b1);
    exp_data("r9_stored", 0, 32'hAA);
    exp_any("r9_any", 1'b1);

    step();
    resv_en = 1'b1; resv_addr = 5'd3;
    step();
    resv_addr = 5'd4;
    set_rd(5'd3, 5'd4);
    exp_busy("r3_busy", 0, 1'b1);
    exp_busy("r4_not_yet", 1, 1'b0);
    step();
    idle();
    exp_busy("r4_busy", 1, 1'b1);
    flush = 1'b1; resv_en = 1'b1; resv_addr = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h88;
    set_rd(5'd6, 5'd3);
    exp_busy("r6_flush_cycle", 0, 1'b0);
    exp_busy("r3_busy_flush_cycle", 1, 1'b1);
    step();
    idle();
    set_rd(5'd6, 5'd4);
    exp_busy("r6_after_flush", 0, 1'b0);
    exp_busy("r4_after_flush", 1, 1'b0);
    exp_any("any_after_flush", 1'b0);
    step();
    set_rd(5'd3, 5'd8);
    exp_busy("r3_after_flush", 0, 1'b0);
    exp_data("r8_written_in_flush", 1, 32'h88);
    step();
    set_rd(5'd5, 5'd9);
    exp_data("r5_kept", 0, 32'hDEAD_BEEF);
    exp_data("r9_kept", 1, 32'hAA);

    step();
    resv_en = 1'b1; resv_addr = 5'd10;
    step();
    idle();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hBB;
    set_rd(5'd10, 5'd5);
    exp_busy("r10_busy_pre_rst", 0, 1'b1);
    exp_data("r5_pre_rst", 1, 32'hDEAD_BEEF);
    exp_any("any_pre_rst", 1'b1);
    step();
    idle();
    set_rd(5'd5, 5'd11);
    exp_data("r5_post_rst", 0, 32'h0);
    exp_data("r11_discarded", 1, 32'h0);
    exp_any("any_post_rst", 1'b0);
    step();
    set_rd(5'd10, 5'd7);
    exp_busy("r10_post_rst", 0, 1'b0);
    exp_data("r7_post_rst", 1, 32'h0);

    step();
    idle();
    set_rd(5'd12, 5'd13);
    #1;
    total++;
    if (rd_data !== 64'h0) begin
      bad++;
      $display("FAIL direct_rst_data: got 0x%016h", rd_data);
    end
    total++;
    if (rd_busy !== 2'b00 || busy_any !== 1'b0) begin
      bad++;
      $display("FAIL direct_rst_busy: rd_busy=%b busy_any=%b", rd_busy, busy_any);
    end

    step();
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h77;
    resv_en = 1'b1; resv_addr = 5'd13;
    #1;
    total++;
    if (rd_data[31:0] !== 32'h77) begin
      bad++;
      $display("FAIL direct_bypass_r12: got 0x%08h", rd_data[31:0]);
    end
    step();
    idle();
    #1;
    total++;
    if (rd_data[31:0] !== 32'h77) begin
      bad++;
      $display("FAIL direct_stored_r12: got 0x%08h", rd_data[31:0]);
    end
    total++;
    if (rd_busy[1] !== 1'b1 || busy_any !== 1'b1) begin
      bad++;
      $display("FAIL direct_r13_busy: rd_busy=%b busy_any=%b", rd_busy, busy_any);
    end
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h99;
    #1;
    total++;
    if (rd_busy[1] !== 1'b0 || rd_data[63:32] !== 32'h99) begin
      bad++;
      $display("FAIL direct_r13_release: rd_busy=%b data=0x%08h", rd_busy, rd_data[63:32]);
    end
    step();
    idle();

    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0 && total > 0) $display("PASS");
    else                       $display("FAIL bad=%0d", bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with a built-in scoreboard, a synchronous clear, and hardwired-zero register 0. It serves as the integer register file of the pipelined core. It provides NUM_RD combinational read ports with write-to-read bypass. A per-register busy bit is set when an instruction reserves its destination and cleared by the matching writeback, so the issue stage can stall on read-after-write hazards.

## Interface
- WIDTH_ADDR, 5, register address width; depth is 2**WIDTH_ADDR
- WIDTH_DATA, 32, register data width
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and reservations
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- rd_addr  input  NUM_RD*WIDTH_ADDR  packed read addresses; port i at [i*WIDTH_ADDR +: WIDTH_ADDR]
- rd_data  output  NUM_RD*WIDTH_DATA  packed read data; port i at [i*WIDTH_DATA +: WIDTH_DATA]
- rd_busy  output  NUM_RD  port i's register has an outstanding reservation
- wr_en  input  1  writeback strobe
- wr_addr  input  WIDTH_ADDR  writeback address
- wr_data  input  WIDTH_DATA  writeback data
- resv_en  input  1  reserve destination register (issue)
- resv_addr  input  WIDTH_ADDR  register to mark busy
- flush  input  1  clear all busy bits; register contents retained
- busy_any  output  1  OR of all busy bits (registered state, not bypassed)

## Operation
- Storage: 2**WIDTH_ADDR x WIDTH_DATA registers, plus a busy vector of the same depth.
- Reset (rst=1 at edge):
  - all registers <= 0 and all busy <= 0, regardless of other inputs.
  - Outputs after reset: rd_data=0 for all addresses, rd_busy=0, busy_any=0.
- Write: if wr_en and the address is writable, regs[wr_addr] <= wr_data. Address 0 is not writable when ZERO_REG=1.
- Read port i, combinational, in priority order:
  - 0 if ZERO_REG and rd_addr_i==0;
  - else wr_data if wr_en and wr_addr==rd_addr_i (bypass);
  - else regs[rd_addr_i].
- Busy update each edge, highest priority first:
  - rst clears all busy bits.
  - flush clears all busy bits; resv_en in the same cycle is ignored.
  - resv_en sets busy[resv_addr].
  - wr_en clears busy[wr_addr].
- Reserve and write to the same register in the same cycle: busy stays set, because a new producer supersedes the old one. Data is still written.
- Reservation of address 0 when ZERO_REG=1: ignored.
- rd_busy_i = busy[rd_addr_i] AND NOT (wr_en AND wr_addr==rd_addr_i). A same-cycle writeback therefore releases the stall immediately. rd_busy_i is forced to 0 for address 0 when ZERO_REG=1.
- A write during flush is performed normally.
- No handshake. Writes to a non-busy register are legal and simply update the data.

## Timing
- Read latency: 0 cycles (combinational from rd_addr and write inputs).
- Write: committed at the edge. It is visible through the bypass in the same cycle and from storage in later cycles.
- Reservation: rd_busy rises the cycle after resv_en.
- Release: rd_busy falls combinationally in the writeback cycle and stays low afterwards.
- busy_any reflects registered busy only; it updates one cycle after resv_en, wr_en or flush.
- Reset asserted mid-operation: takes effect at the next edge. Pending reservations and register data are lost, and any in-flight writeback in that cycle is discarded.

## Structure
- Package reg_file_pkg: default WIDTH_ADDR/WIDTH_DATA constants, REG_ZERO address constant, typedefs reg_addr_t and reg_data_t.
- Sub-module reg_scoreboard: the busy vector, its set/clear/flush priority logic, and busy_any. It is parameterised on depth only.
- Read ports are generated with a generate loop over NUM_RD.

## Test plan
- Reset, then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, busy_any=0.
- Write 0xDEADBEEF to r5 while reading r5 in the same cycle -> rd_data=0xDEADBEEF that cycle (bypass) and in the next cycle (storage).
- Write 0x12345678 to r0, then read r0 with ZERO_REG=1 -> 0. Reserve r0 -> rd_busy=0 and busy_any=0.
- Reserve r7 at cycle 0 -> rd_busy(r7)=1 and busy_any=1 from cycle 1. Writeback r7=0x55 at cycle 3 -> rd_busy=0 and rd_data=0x55 in cycle 3; busy_any=0 in cycle 4.
- Reserve r9 and write back r9=0xAA in the same cycle -> rd_busy(r9)=1 next cycle and data reads 0xAA.
- Reserve r3 and r4, then assert flush together with resv_en(r6) -> next cycle r3/r4/r6 not busy, data intact. Assert rst mid-sequence -> all data 0 next cycle.
